// File: rtl/mhd_err_monitor.sv
// mhd_err_monitor: streams exact/approximate word pairs through a Hamming-distance
// pipeline and accumulates error statistics against a programmable bound.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               job start pulse (honoured only when idle)
//   num_samples         samples per job, latched on an honoured start
//   mhd_thr             max Hamming distance, latched on an honoured start
//   in_valid/in_ready   a/b pair handshake; a pair is taken when both are high
//   a, b                exact and approximate output words
//   busy                job in progress (RUN or DRAIN)
//   done                one-cycle pulse when results are final
//   err_cnt             saturating count of samples with hd > mhd_thr
//   max_hd              largest hd seen in the job
//   first_err_vld/idx   whether an error occurred and the index of the first one
module mhd_err_monitor #(
    parameter int WIDTH = 33,
    parameter int SUM_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [SUM_W-1:0] mhd_thr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] max_hd,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] n_lat, acc_cnt, idx1, idx2;
    logic [SUM_W-1:0] thr_lat, hd, hd2;
    logic [WIDTH-1:0] diff1;
    logic             v1, v2, accept, err;
    assign accept = in_valid & in_ready;
    assign err    = v2 && (hd2 > thr_lat);
    always_comb begin
        hd = '0;
        for (int i = 0; i < WIDTH; i++) hd = hd + SUM_W'(diff1[i]);
    end
    // Control FSM; in_ready, busy and done are registered state decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            n_lat    <= '0;
            thr_lat  <= '0;
            acc_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    n_lat   <= num_samples;
                    thr_lat <= mhd_thr;
                    acc_cnt <= '0;
                    if (num_samples == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                RUN: if (accept) begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                    if (acc_cnt + CNT_W'(1) == n_lat) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                // The stage-2 sample retires on the same edge that enters DONE,
                // so only stage 1 has to be empty here.
                DRAIN: if (!v1) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Three-edge datapath: capture diff, register popcount, update statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            diff1         <= '0;
            idx1          <= '0;
            idx2          <= '0;
            hd2           <= '0;
            err_cnt       <= '0;
            max_hd        <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            v1    <= accept;
            diff1 <= accept ? a ^ b : diff1;
            idx1  <= accept ? acc_cnt : idx1;
            v2    <= v1;
            hd2   <= hd;
            idx2  <= idx1;
            if (state == IDLE && start) begin
                err_cnt       <= '0;
                max_hd        <= '0;
                first_err_vld <= 1'b0;
                first_err_idx <= '0;
            end else if (v2) begin
                err_cnt       <= (err && err_cnt != '1) ? err_cnt + CNT_W'(1) : err_cnt;
                max_hd        <= (hd2 > max_hd) ? hd2 : max_hd;
                first_err_vld <= first_err_vld | err;
                first_err_idx <= (err && !first_err_vld) ? idx2 : first_err_idx;
            end
        end
    end
endmodule

// File: tb/tb_mhd_err_monitor.sv
// tb_mhd_err_monitor: scoreboard bench for mhd_err_monitor with directed jobs.
module tb_mhd_err_monitor;
    localparam int W = 33;
    localparam int S = 6;
    localparam int C = 32;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, start_s = 0;
    logic [C-1:0] num_samples = '0;
    logic [S-1:0] mhd_thr = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0] ns_s = '0;
    logic in_ready, busy, done, first_err_vld;
    logic [C-1:0] err_cnt, first_err_idx;
    logic [S-1:0] max_hd;
    logic in_ready_s, busy_s, done_s, fv_s;
    logic [2:0] err_cnt_s, fi_s;
    logic [S-1:0] max_hd_s;

    mhd_err_monitor #(.WIDTH(W), .SUM_W(S), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .mhd_thr(mhd_thr),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .busy(busy), .done(done),
        .err_cnt(err_cnt), .max_hd(max_hd), .first_err_vld(first_err_vld),
        .first_err_idx(first_err_idx));

    // Narrow-counter instance used only for the saturation job.
    mhd_err_monitor #(.WIDTH(W), .SUM_W(S), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .num_samples(ns_s), .mhd_thr(mhd_thr),
        .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .busy(busy_s), .done(done_s),
        .err_cnt(err_cnt_s), .max_hd(max_hd_s), .first_err_vld(fv_s), .first_err_idx(fi_s));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [C-1:0] e;
        logic [S-1:0] m;
        logic         fv;
        logic [C-1:0] fi;
        int           dcyc;
    } exp_t;
    exp_t sb[$];
    exp_t x;
    int n_cmp = 0, n_bad = 0, n_done = 0, last_acc = 0;
    logic [W-1:0] va[8], vb[8];

    task automatic chk(string nm, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expected result set.
    always @(negedge clk) if (!rst && done) begin
        n_done++;
        chk("sb_nonempty_at_done", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("err_cnt", err_cnt, x.e);
            chk("max_hd", max_hd, x.m);
            chk("first_err_vld", first_err_vld, x.fv);
            chk("first_err_idx", first_err_idx, x.fi);
            chk("done_cycle", cyc, x.dcyc);
            chk("busy_at_done", busy, 0);
        end
    end

    function automatic logic [W-1:0] ones(int k);
        logic [W-1:0] o = '1;
        return k == 0 ? '0 : o >> (W - k);
    endfunction

    task automatic set_hd(int i, int k);
        va[i] = '0;
        vb[i] = ones(k);
    endtask

    task automatic start_job(int n, int thr, logic [C-1:0] e, logic [S-1:0] m, logic fv, logic [C-1:0] fi);
        start = 1;
        num_samples = C'(n);
        mhd_thr = S'(thr);
        sb.push_back('{e, m, fv, fi, cyc + 1});
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic feed(int off, int cnt, bit tog, bit sel);
        int idx = 0, bud = 0;
        bit ph = 1;
        while (idx < cnt && bud < 100) begin
            a = va[off + idx];
            b = vb[off + idx];
            in_valid = tog ? ph : 1'b1;
            ph = !ph;
            if (in_valid && (sel ? in_ready_s : in_ready)) begin
                idx++;
                last_acc = cyc + 1;
            end
            @(posedge clk);
            #1;
            bud++;
        end
        in_valid = 0;
        chk("feed_accepts", idx, cnt);
    endtask

    task automatic set_dcyc();
        if (sb.size() > 0) sb[sb.size() - 1].dcyc = last_acc + 2;
    endtask

    task automatic wait_sb();
        int bud = 0;
        while (sb.size() > 0 && bud < 20) begin
            @(posedge clk);
            #1;
            bud++;
        end
        chk("pending_jobs_after_wait", sb.size(), 0);
        sb.delete();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_max_hd"}, max_hd, 0);
        chk({tag, "_first_err_vld"}, first_err_vld, 0);
        chk({tag, "_first_err_idx"}, first_err_idx, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int extra, bsy, bud;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 0;
        @(posedge clk);
        #1;
        // Job 1: hd 4 then 5, thr 4
        set_hd(0, 4); set_hd(1, 5);
        start_job(2, 4, 1, 5, 1, 1);
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, 1);
        feed(0, 2, 0, 0);
        set_dcyc();
        chk("in_ready_after_last", in_ready, 0);
        chk("busy_in_drain", busy, 1);
        wait_sb();
        // Job 2: identical words, thr 0
        for (int i = 0; i < 3; i++) begin va[i] = 33'h1_2345_6789; vb[i] = 33'h1_2345_6789; end
        start_job(3, 0, 0, 0, 0, 0);
        feed(0, 3, 0, 0);
        set_dcyc();
        wait_sb();
        // Job 3: complementary words, hd 33
        for (int i = 0; i < 3; i++) begin va[i] = 33'h0_AAAA_AAAA; vb[i] = ~va[i]; end
        start_job(3, 0, 3, 33, 1, 0);
        feed(0, 3, 0, 0);
        set_dcyc();
        wait_sb();
        // Job 4: backpressure, hd 1,3,2,5 thr 2
        set_hd(0, 1); set_hd(1, 3); set_hd(2, 2); set_hd(3, 5);
        start_job(4, 2, 2, 5, 1, 1);
        feed(0, 4, 1, 0);
        set_dcyc();
        chk("bp_in_ready_after_last", in_ready, 0);
        extra = 0;
        a = '0; b = '1; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            if (in_valid && in_ready) extra++;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        chk("bp_extra_accepts", extra, 0);
        wait_sb();
        // Job 5: zero samples
        bsy = 0;
        start_job(0, 7, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bsy |= int'(busy);
            @(posedge clk);
            #1;
        end
        chk("n0_busy_seen", bsy, 0);
        wait_sb();
        // Job 6: start during RUN is ignored; hd 0,1,2 thr 1
        set_hd(0, 0); set_hd(1, 1); set_hd(2, 2);
        start_job(3, 1, 1, 2, 1, 2);
        feed(0, 1, 0, 0);
        start = 1; num_samples = 10; mhd_thr = 0;
        @(posedge clk);
        #1 start = 0;
        feed(1, 2, 0, 0);
        set_dcyc();
        wait_sb();
        // Job 7: reset mid-run after two erring samples retire
        for (int i = 0; i < 4; i++) set_hd(i, 1);
        start_job(5, 0, 0, 0, 0, 0);
        feed(0, 4, 0, 0);
        chk("pre_reset_err_cnt", err_cnt, 2);
        rst = 1;
        #1 chk_zero("midrun_reset");
        sb.delete();
        @(negedge clk) rst = 0;
        repeat (5) @(posedge clk);
        #1;
        // Job 8: normal job after reset, hd 4,3 thr 3
        set_hd(0, 4); set_hd(1, 3);
        start_job(2, 3, 1, 4, 1, 0);
        feed(0, 2, 0, 0);
        set_dcyc();
        wait_sb();
        // Saturation on the 3-bit counter instance
        for (int i = 0; i < 7; i++) set_hd(i, 1);
        start_s = 1; ns_s = 3'd7; mhd_thr = 0;
        @(posedge clk);
        #1 start_s = 0;
        feed(0, 7, 0, 1);
        bud = 0;
        while (!done_s && bud < 20) begin
            @(posedge clk);
            #1;
            bud++;
        end
        chk("sat_done_seen", done_s, 1);
        chk("sat_err_cnt", err_cnt_s, 7);
        chk("sat_first_err_idx", fi_s, 0);
        chk("sat_max_hd", max_hd_s, 1);
        repeat (3) @(posedge clk);
        #1 chk("done_total", n_done, 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
